// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared LFSR constants, single-shift step function and select-width helper
package lfsr_pkg;
  localparam int MAX_W = 64;
  localparam logic [7:0] TAPS_W8 = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [31:0] TAPS_W32 = 32'h80200003;
  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
  // returns {fb, next_state}; state bits at and above width must be zero
  function automatic logic [MAX_W:0] lfsr_step(input logic [MAX_W-1:0] state,
                                               input logic [MAX_W-1:0] taps,
                                               input int width);
    logic fb;
    logic [MAX_W-1:0] mask;
    fb = ^(state & taps);
    mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
    return {fb, ((state << 1) | MAX_W'(fb)) & mask};
  endfunction
endpackage

// File: rtl/lfsr_chan.sv
// lfsr_chan: one LFSR channel with STEPS-unrolled shifting, seed load and zero-seed fallback
module lfsr_chan import lfsr_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int STEPS = 1,
  parameter logic [WIDTH-1:0] TAPS = TAPS_W8,
  parameter logic [WIDTH-1:0] SEED = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] state,
  output logic [STEPS-1:0] coin_bits,
  output logic             zero_seed
);
  logic [WIDTH-1:0] state_d, state_q, walk;
  logic [STEPS-1:0] raw;
  logic [MAX_W:0] r;
  always_comb begin
    walk = state_q;
    raw = '0;
    r = '0;
    for (int k = 0; k < STEPS; k++) begin
      r = lfsr_step(MAX_W'(walk), MAX_W'(TAPS), WIDTH);
      raw[k] = r[MAX_W];
      walk = r[WIDTH-1:0];
    end
    zero_seed = load & (load_data == '0);
    coin_bits = load ? '0 : raw;
    state_d = load ? (zero_seed ? SEED : load_data) : (step ? walk : state_q);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= SEED;
    else state_q <= state_d;
  assign state = state_q;
  a_no_lockup: assert property (@(posedge clk) disable iff (!rst) state_q != '0);
endmodule

// File: rtl/lfsr_coin_gen.sv
// lfsr_coin_gen: multi-channel LFSR coin source with valid/ready output register
module lfsr_coin_gen import lfsr_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int NUM_CH = 2,
  parameter int STEPS = 1,
  parameter logic [WIDTH-1:0] TAPS = TAPS_W8,
  parameter logic [NUM_CH*WIDTH-1:0] DEF_SEED = {8'h01, 8'hFF}
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      seed_load,
  input  logic [sel_w(NUM_CH)-1:0]  seed_ch,
  input  logic [WIDTH-1:0]          seed_data,
  output logic [NUM_CH*STEPS-1:0]   coins,
  output logic                      coins_valid,
  input  logic                      coins_ready,
  output logic                      lockup_err,
  output logic [NUM_CH*WIDTH-1:0]   state_dbg
);
  localparam int CH_W = sel_w(NUM_CH);
  logic step;
  logic [NUM_CH*STEPS-1:0] bits, coins_d, coins_q;
  logic [NUM_CH-1:0] zero;
  logic coins_valid_d, coins_valid_q, lockup_err_d, lockup_err_q;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    lfsr_chan #(
      .WIDTH(WIDTH), .STEPS(STEPS), .TAPS(TAPS), .SEED(DEF_SEED[c*WIDTH +: WIDTH])
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .step      (step),
      .load      (seed_load && (seed_ch == CH_W'(c))),
      .load_data (seed_data),
      .state     (state_dbg[c*WIDTH +: WIDTH]),
      .coin_bits (bits[c*STEPS +: STEPS]),
      .zero_seed (zero[c])
    );
  end
  always_comb begin
    step = en & (~coins_valid_q | coins_ready);
    coins_d = step ? bits : coins_q;
    coins_valid_d = step ? 1'b1 : (coins_ready ? 1'b0 : coins_valid_q);
    lockup_err_d = lockup_err_q | (|zero);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      coins_q <= '0;
      coins_valid_q <= 1'b0;
      lockup_err_q <= 1'b0;
    end else begin
      coins_q <= coins_d;
      coins_valid_q <= coins_valid_d;
      lockup_err_q <= lockup_err_d;
    end
  assign coins = coins_q;
  assign coins_valid = coins_valid_q;
  assign lockup_err = lockup_err_q;
endmodule
